// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the M-stage store buffer: controller state encoding,
// byte-enable constants and the word-alignment mask for bus addresses.
package dm_store_buffer_pkg;

    // Controller states: no bus activity, buffered write in flight, load read in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;
    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    // AND-ing a byte address with this mask clears the in-word byte offset.
    // Wide enough for any address width up to 64 bits; users slice the low bits.
    localparam logic [63:0] WORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/dm_wbuf_slot.sv
// One-entry write buffer slot. Holds a word-aligned store (address, byte
// enables, data) plus a valid flag. When load and clear coincide, load wins so
// the controller can retire one store and capture the next in the same cycle.
module dm_wbuf_slot
    import dm_store_buffer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DATA_W/8-1:0]   load_byteen,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  valid,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W/8-1:0]   byteen,
    output logic [DATA_W-1:0]     data
);

    // Valid flag: set on load, dropped on clear, load has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid, so it is captured without reset
    always_ff @(posedge clk) begin
        if (load) begin
            addr   <= load_addr;
            byteen <= load_byteen;
            data   <= load_data;
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// M-stage data-memory front end. Stores are absorbed by a one-entry write
// buffer and drained over a req/ack bus; loads stall the pipeline until their
// read returns. The buffer is always drained before a load's read is issued,
// so a load can never observe memory older than a preceding store.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_req_valid,
    input  logic                  m_req_we,
    input  logic [ADDR_W-1:0]     m_req_addr,
    input  logic [DATA_W/8-1:0]   m_data_byteen,
    input  logic [DATA_W-1:0]     m_data_wdata,
    output logic                  m_stall,
    output logic [DATA_W-1:0]     m_rdata,
    output logic                  m_rdata_valid,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_byteen,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int                BE_W       = DATA_W / 8;
    localparam logic [BE_W-1:0]   BE_NONE    = BE_W'(BYTEEN_NONE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = WORD_ALIGN_MASK[ADDR_W-1:0];

    state_e              state;
    state_e              state_nxt;

    logic [ADDR_W-1:0]   aligned_addr;
    logic                is_store;
    logic                is_load;
    logic                store_nop;
    logic                ack_hit;
    logic                wr_done;
    logic                rd_done;
    logic                store_accept;

    logic                buf_valid;
    logic [ADDR_W-1:0]   buf_addr;
    logic [BE_W-1:0]     buf_byteen;
    logic [DATA_W-1:0]   buf_data;

    logic                bus_req_nxt;
    logic                bus_we_nxt;
    logic [ADDR_W-1:0]   bus_addr_nxt;
    logic [BE_W-1:0]     bus_byteen_nxt;
    logic [DATA_W-1:0]   bus_wdata_nxt;

    // Decode the M-stage request and derive accept/stall from buffer and bus status
    always_comb begin
        aligned_addr = m_req_addr & ALIGN_MASK;
        is_store     = m_req_valid & m_req_we;
        is_load      = m_req_valid & ~m_req_we;
        store_nop    = is_store & (m_data_byteen == BE_NONE);
        // An ack only counts while a request is actually outstanding
        ack_hit      = bus_req & bus_ack;
        wr_done      = (state == ST_WR) & ack_hit;
        rd_done      = (state == ST_RD) & ack_hit;
        // The slot frees up in the write-ack cycle, so a store can slip in then
        store_accept = is_store & ~store_nop & (~buf_valid | wr_done);

        m_stall = 1'b0;
        if (is_store) begin
            m_stall = ~(store_nop | store_accept);
        end else if (is_load) begin
            m_stall = ~rd_done;
        end
    end

    dm_wbuf_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (store_accept),
        .clear       (wr_done),
        .load_addr   (aligned_addr),
        .load_byteen (m_data_byteen),
        .load_data   (m_data_wdata),
        .valid       (buf_valid),
        .addr        (buf_addr),
        .byteen      (buf_byteen),
        .data        (buf_data)
    );

    // Controller state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a valid buffer always wins over a waiting load
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (buf_valid) begin
                    state_nxt = ST_WR;
                end else if (is_load) begin
                    state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                if (wr_done) begin
                    state_nxt = store_accept ? ST_WR : ST_IDLE;
                end
            end
            ST_RD: begin
                if (rd_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus output values for next cycle; held unchanged while a request waits for ack
    always_comb begin
        bus_req_nxt    = bus_req;
        bus_we_nxt     = bus_we;
        bus_addr_nxt   = bus_addr;
        bus_byteen_nxt = bus_byteen;
        bus_wdata_nxt  = bus_wdata;
        unique case (state)
            ST_IDLE: begin
                if (buf_valid) begin
                    bus_req_nxt    = 1'b1;
                    bus_we_nxt     = 1'b1;
                    bus_addr_nxt   = buf_addr;
                    bus_byteen_nxt = buf_byteen;
                    bus_wdata_nxt  = buf_data;
                end else if (is_load) begin
                    bus_req_nxt    = 1'b1;
                    bus_we_nxt     = 1'b0;
                    bus_addr_nxt   = aligned_addr;
                    bus_byteen_nxt = BE_NONE;
                    bus_wdata_nxt  = '0;
                end
            end
            ST_WR: begin
                if (wr_done) begin
                    if (store_accept) begin
                        // Back-to-back write straight from the store being accepted
                        bus_req_nxt    = 1'b1;
                        bus_we_nxt     = 1'b1;
                        bus_addr_nxt   = aligned_addr;
                        bus_byteen_nxt = m_data_byteen;
                        bus_wdata_nxt  = m_data_wdata;
                    end else begin
                        bus_req_nxt = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (rd_done) begin
                    bus_req_nxt = 1'b0;
                end
            end
            default: bus_req_nxt = 1'b0;
        endcase
    end

    // Registered bus outputs and load return; reset drops any request at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_byteen    <= '0;
            bus_wdata     <= '0;
            m_rdata       <= '0;
            m_rdata_valid <= 1'b0;
        end else begin
            bus_req       <= bus_req_nxt;
            bus_we        <= bus_we_nxt;
            bus_addr      <= bus_addr_nxt;
            bus_byteen    <= bus_byteen_nxt;
            bus_wdata     <= bus_wdata_nxt;
            m_rdata_valid <= rd_done;
            if (rd_done) begin
                m_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: a bus responder with its own memory, a program-
// order memory model for expected load data and bus transactions, directed
// scenarios for timing corners and a randomized mix of loads and stores.
module tb_dm_store_buffer;
    import dm_store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req_valid;
    logic        m_req_we;
    logic [31:0] m_req_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_wdata;
    logic        m_stall;
    logic [31:0] m_rdata;
    logic        m_rdata_valid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    dm_store_buffer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_req_valid   (m_req_valid),
        .m_req_we      (m_req_we),
        .m_req_addr    (m_req_addr),
        .m_data_byteen (m_data_byteen),
        .m_data_wdata  (m_data_wdata),
        .m_stall       (m_stall),
        .m_rdata       (m_rdata),
        .m_rdata_valid (m_rdata_valid),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_byteen    (bus_byteen),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } bus_txn_t;

    bus_txn_t    exp_bus[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] bus_mem[int unsigned];

    int checks     = 0;
    int errors     = 0;
    int req_cycles = 0;
    int fixed_lat  = -1;

    function automatic logic [31:0] word_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : word_init(a);
    endfunction

    function automatic logic [31:0] bus_read(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : word_init(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Bus responder: random or fixed ack latency, spurious acks while idle
    int responder_cnt  = 0;
    bit r_prev_req     = 1'b0;
    bit r_prev_ack     = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            if (!r_prev_req || r_prev_ack) begin
                responder_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (responder_cnt == 0) begin
                bus_ack = 1'b1;
                if (bus_we) bus_mem[bus_addr] = merge(bus_read(bus_addr), bus_wdata, bus_byteen);
                else        bus_rdata = bus_read(bus_addr);
            end else begin
                bus_ack = 1'b0;
                responder_cnt--;
                bus_rdata = $urandom;
            end
        end else begin
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end
        r_prev_req = bus_req;
        r_prev_ack = bus_ack;
    end

    // Monitor: scoreboard pops on bus acks and load returns, plus hold checks
    bit          m_prev_req = 1'b0;
    bit          m_prev_ack = 1'b0;
    logic [68:0] m_prev_bus;
    always @(negedge clk) begin
        bus_txn_t t;
        if (!reset) begin
            m_prev_req = 1'b0;
            m_prev_ack = 1'b0;
        end else begin
            if (m_prev_req && !m_prev_ack && bus_req) begin
                check("bus_hold", 32'({bus_we, bus_addr, bus_byteen, bus_wdata} == m_prev_bus), 1);
            end
            if (bus_req) req_cycles++;
            if (bus_req && bus_ack) begin
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected_txn", 1, 0);
                end else begin
                    t = exp_bus.pop_front();
                    check("bus_we", 32'(bus_we), 32'(t.we));
                    check("bus_addr", bus_addr, t.addr);
                    check("bus_byteen", 32'(bus_byteen), 32'(t.be));
                    if (t.we) check("bus_wdata", bus_wdata, t.data);
                end
            end
            if (m_rdata_valid) begin
                if (exp_rd.size() == 0) check("rdata_unexpected", 1, 0);
                else                    check("m_rdata", m_rdata, exp_rd.pop_front());
            end
            m_prev_req = bus_req;
            m_prev_ack = bus_ack;
            m_prev_bus = {bus_we, bus_addr, bus_byteen, bus_wdata};
        end
    end

    // Present one M-stage operation and hold it until it is no longer stalled
    task automatic do_op(input bit valid, input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data, output int stalls);
        bus_txn_t    t;
        logic [31:0] wa;
        @(posedge clk); #1;
        m_req_valid   = valid;
        m_req_we      = we;
        m_req_addr    = addr;
        m_data_byteen = be;
        m_data_wdata  = data;
        wa = addr & 32'hFFFF_FFFC;
        if (valid && we && be != 4'b0000) begin
            t = '{1'b1, wa, be, data};
            exp_bus.push_back(t);
            ref_mem[wa] = merge(ref_read(wa), data, be);
        end else if (valid && !we) begin
            t = '{1'b0, wa, 4'b0000, 32'h0};
            exp_bus.push_back(t);
            exp_rd.push_back(ref_read(wa));
        end
        stalls = 0;
        @(negedge clk);
        if (!valid)           check("idle_no_stall", 32'(m_stall), 0);
        else if (!we)         check("load_first_stall", 32'(m_stall), 1);
        else if (be == 4'b0)  check("nop_store_no_stall", 32'(m_stall), 0);
        while (m_stall) begin
            stalls++;
            if (stalls > 200) begin
                check("stall_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_op();
        int s;
        do_op(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, s);
    endtask

    // Wait for three quiet bus cycles, which also implies an empty buffer
    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 200) begin
            @(negedge clk);
            n++;
            quiet = bus_req ? 0 : quiet + 1;
        end
        check("drain_timeout", 32'(quiet >= 3), 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          s2;
        int          r;
        int          bad;
        logic [31:0] exp_val;
        logic [31:0] a;
        bus_txn_t    t;

        reset         = 1'b0;
        m_req_valid   = 1'b0;
        m_req_we      = 1'b0;
        m_req_addr    = 32'h0;
        m_data_byteen = 4'b0000;
        m_data_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_bus_we", 32'(bus_we), 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_byteen", 32'(bus_byteen), 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_m_rdata_valid", 32'(m_rdata_valid), 0);
        check("rst_m_stall", 32'(m_stall), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single store, ack after two wait cycles
        fixed_lat = 2;
        wait_idle();
        req_cycles = 0;
        do_op(1'b1, 1'b1, 32'h0000_1006, 4'b1100, 32'hBEEF_0000, s);
        check("single_store_stalls", s, 0);
        idle_op();
        wait_idle();
        check("single_store_req_cycles", req_cycles, 3);

        // Back-to-back stores with zero-wait bus
        fixed_lat = 0;
        wait_idle();
        req_cycles = 0;
        do_op(1'b1, 1'b1, 32'h0000_0010, 4'b1111, 32'h1111_0010, s);
        check("b2b_first_stalls", s, 0);
        do_op(1'b1, 1'b1, 32'h0000_0014, 4'b1111, 32'h2222_0014, s2);
        idle_op();
        wait_idle();
        check("b2b_req_cycles", req_cycles, 2);

        // Store then load to the same word: load must see the stored value
        fixed_lat = 1;
        wait_idle();
        do_op(1'b1, 1'b1, 32'h0000_0200, BYTEEN_WORD, 32'h1234_5678, s);
        do_op(1'b1, 1'b0, 32'h0000_0202, 4'b0000, 32'h0, s);
        idle_op();
        check("st_ld_rvalid", 32'(m_rdata_valid), 1);
        check("st_ld_rdata", m_rdata, 32'h1234_5678);
        @(negedge clk);
        check("st_ld_rvalid_pulse", 32'(m_rdata_valid), 0);

        // Minimum load latency with empty buffer and zero-wait bus
        fixed_lat = 0;
        wait_idle();
        @(posedge clk); #1;
        m_req_valid = 1'b1;
        m_req_we    = 1'b0;
        m_req_addr  = 32'h0000_0044;
        exp_val     = ref_read(32'h0000_0044);
        t = '{1'b0, 32'h0000_0044, 4'b0000, 32'h0};
        exp_bus.push_back(t);
        exp_rd.push_back(exp_val);
        @(negedge clk);
        check("lat_t_stall", 32'(m_stall), 1);
        check("lat_t_req", 32'(bus_req), 0);
        @(negedge clk);
        check("lat_t1_req", 32'(bus_req), 1);
        check("lat_t1_ack", 32'(bus_ack), 1);
        check("lat_t1_stall", 32'(m_stall), 0);
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        @(negedge clk);
        check("lat_t2_rvalid", 32'(m_rdata_valid), 1);
        check("lat_t2_rdata", m_rdata, exp_val);
        @(negedge clk);
        check("lat_t3_rvalid", 32'(m_rdata_valid), 0);

        // Zero-enable store is a no-op
        fixed_lat = -1;
        wait_idle();
        req_cycles = 0;
        do_op(1'b1, 1'b1, 32'h0000_0080, 4'b0000, 32'hDEAD_BEEF, s);
        check("nop_store_stalls", s, 0);
        idle_op();
        repeat (4) @(negedge clk);
        check("nop_store_req_cycles", req_cycles, 0);

        // Reset while a read is outstanding
        fixed_lat = 6;
        wait_idle();
        @(posedge clk); #1;
        m_req_valid = 1'b1;
        m_req_we    = 1'b0;
        m_req_addr  = 32'h0000_0300;
        repeat (2) @(negedge clk);
        check("rst_rd_req_before", 32'(bus_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_rd_req_dropped", 32'(bus_req), 0);
        check("rst_rd_rvalid", 32'(m_rdata_valid), 0);
        m_req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        fixed_lat = -1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_rdata_valid || bus_req) bad++;
        end
        check("rst_rd_quiet_after", bad, 0);

        // Randomized mix of stores, loads, no-op stores and idle cycles
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            if (r < 40)      do_op(1'b1, 1'b1, a, 4'($urandom_range(1, 15)), $urandom, s);
            else if (r < 70) do_op(1'b1, 1'b0, a, 4'b0000, 32'h0, s);
            else if (r < 80) do_op(1'b1, 1'b1, a, 4'b0000, $urandom, s);
            else             idle_op();
        end
        idle_op();
        wait_idle();
        repeat (2) @(negedge clk);
        check("bus_queue_empty", exp_bus.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
